// File: rtl/io_2to1.sv
// io_2to1: two independent sequenced sources feeding a merge node and a checking sink
// that flags header, redundancy, ordering and handshake errors on sticky debug LEDs.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 4
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module calc_redun #(
  parameter int ASZ = 4,
  parameter int DSZ = 8,
  parameter int RSZ = 4
) (
  input  logic [ASZ-1:0] src,
  input  logic [ASZ-1:0] dst,
  input  logic [DSZ-1:0] dat,
  output logic [RSZ-1:0] red
);
  localparam int W  = 2 * ASZ + DSZ;
  localparam int N  = (W + RSZ - 1) / RSZ;
  localparam int VW = N * RSZ;
  logic [VW-1:0] v;
  assign v = VW'({src, dst, dat});
  // XOR-fold the whole header+payload into RSZ-bit chunks
  always_comb begin
    red = '0;
    for (int i = 0; i < N; i++) red ^= v[i*RSZ +: RSZ];
  end
endmodule

module io_src #(
  parameter int ASZ = 4,
  parameter int DSZ = 8,
  parameter int RSZ = 4,
  parameter logic [ASZ-1:0] SRC = '0,
  parameter logic [ASZ-1:0] DST = '0,
  parameter int GAP = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  output logic [ASZ-1:0] src,
  output logic [ASZ-1:0] dst,
  output logic [DSZ-1:0] dat,
  output logic [RSZ-1:0] red,
  output logic           req,
  input  logic           ack
);
  typedef enum logic [2:0] {S_IDLE, S_BUILD_DAT, S_BUILD_RED, S_REQ, S_REL, S_GAP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [7:0] gcnt;
  logic [RSZ-1:0] red_nx;
  assign src = SRC;
  assign dst = DST;
  assign req = state == S_REQ;
  calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_red (.src(SRC), .dst(DST), .dat(dat), .red(red_nx));
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      state_nx = ack ? S_IDLE : S_BUILD_DAT;
      S_BUILD_DAT: state_nx = S_BUILD_RED;
      S_BUILD_RED: state_nx = S_REQ;
      S_REQ:       state_nx = ack ? S_REL : S_REQ;
      S_REL:       state_nx = ack ? S_REL : (GAP == 0 ? S_IDLE : S_GAP);
      S_GAP:       state_nx = gcnt == 8'(GAP - 1) ? S_IDLE : S_GAP;
      default:     state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      gcnt  <= '0;
      dat   <= '0;
      red   <= '0;
    end else begin
      state <= state_nx;
      gcnt  <= state == S_GAP ? gcnt + 8'd1 : '0;
      if (state == S_BUILD_DAT) begin
        dat <= DSZ'(cnt);
        cnt <= cnt + 4'd1;
      end
      if (state == S_BUILD_RED) red <= red_nx;
    end
  end
endmodule

module io_2to1 #(
  parameter int DST_ADDR  = 1,
  parameter int SRC0_ADDR = 9,
  parameter int SRC1_ADDR = 10,
  parameter int GAP0      = 0,
  parameter int GAP1      = 3,
  parameter int ASZ       = `NS_ADDRESS_SIZE,
  parameter int DSZ       = `NS_DATA_SIZE,
  parameter int RSZ       = `NS_REDUN_SIZE
) (
  input  logic           clk,
  input  logic           reset_n,
  output logic [ASZ-1:0] o0_src,
  output logic [ASZ-1:0] o0_dst,
  output logic [DSZ-1:0] o0_dat,
  output logic [RSZ-1:0] o0_red,
  output logic           o0_req,
  input  logic           o0_ack,
  output logic [ASZ-1:0] o1_src,
  output logic [ASZ-1:0] o1_dst,
  output logic [DSZ-1:0] o1_dat,
  output logic [RSZ-1:0] o1_red,
  output logic           o1_req,
  input  logic           o1_ack,
  input  logic [ASZ-1:0] i0_src,
  input  logic [ASZ-1:0] i0_dst,
  input  logic [DSZ-1:0] i0_dat,
  input  logic [RSZ-1:0] i0_red,
  input  logic           i0_req,
  output logic           i0_ack,
  output logic [3:0]     dbg_leds,
  output logic [3:0]     dbg_disp0,
  output logic [3:0]     dbg_disp1
);
  localparam logic [ASZ-1:0] DA  = ASZ'(DST_ADDR);
  localparam logic [ASZ-1:0] SA0 = ASZ'(SRC0_ADDR);
  localparam logic [ASZ-1:0] SA1 = ASZ'(SRC1_ADDR);
  io_src #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .SRC(SA0), .DST(DA), .GAP(GAP0)) u_src0 (
    .clk(clk), .reset_n(reset_n), .src(o0_src), .dst(o0_dst), .dat(o0_dat), .red(o0_red),
    .req(o0_req), .ack(o0_ack));
  io_src #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .SRC(SA1), .DST(DA), .GAP(GAP1)) u_src1 (
    .clk(clk), .reset_n(reset_n), .src(o1_src), .dst(o1_dst), .dat(o1_dat), .red(o1_red),
    .req(o1_req), .ack(o1_ack));
  typedef enum logic [2:0] {S_WAIT, S_CAP, S_CALC, S_CHECK, S_ACK} sink_t;
  sink_t st, st_nx;
  logic [ASZ-1:0] l_src, l_dst;
  logic [DSZ-1:0] l_dat;
  logic [RSZ-1:0] l_red, c_red, red_nx;
  logic [3:0] last0, last1, nib;
  logic v0, v1, is0, is1, hdr_err, busy;
  calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_chk (.src(l_src), .dst(l_dst), .dat(l_dat), .red(red_nx));
  assign i0_ack  = st == S_ACK;
  assign nib     = l_dat[3:0];
  assign is0     = l_src == SA0;
  assign is1     = l_src == SA1;
  assign busy    = st == S_CAP || st == S_CALC || st == S_CHECK;
  assign hdr_err = l_dst != DA || !(is0 || is1) || l_red != c_red || (l_dat >> 4) != '0;
  always_comb begin
    st_nx = st;
    case (st)
      S_WAIT:  st_nx = i0_req && !i0_ack ? S_CAP : S_WAIT;
      S_CAP:   st_nx = i0_req ? S_CALC : S_WAIT;
      S_CALC:  st_nx = i0_req ? S_CHECK : S_WAIT;
      S_CHECK: st_nx = i0_req ? S_ACK : S_WAIT;
      S_ACK:   st_nx = i0_req ? S_ACK : S_WAIT;
      default: st_nx = S_WAIT;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st        <= S_WAIT;
      l_src     <= '0;
      l_dst     <= '0;
      l_dat     <= '0;
      l_red     <= '0;
      c_red     <= '0;
      last0     <= '0;
      last1     <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      dbg_leds  <= '0;
      dbg_disp0 <= '0;
      dbg_disp1 <= '0;
    end else begin
      st <= st_nx;
      if (st == S_CAP) begin
        l_src <= i0_src;
        l_dst <= i0_dst;
        l_dat <= i0_dat;
        l_red <= i0_red;
      end
      if (st == S_CALC) c_red <= red_nx;
      // request withdrawn before we acknowledged: abandon the message entirely
      if (busy && !i0_req) dbg_leds[3] <= 1'b1;
      if (st == S_CHECK && i0_req) begin
        if (hdr_err) dbg_leds[0] <= 1'b1;
        if (is0) begin
          if (v0 && nib != last0 + 4'd1) dbg_leds[1] <= 1'b1;
          last0     <= nib;
          v0        <= 1'b1;
          dbg_disp0 <= nib;
        end
        if (is1) begin
          if (v1 && nib != last1 + 4'd1) dbg_leds[2] <= 1'b1;
          last1     <= nib;
          v1        <= 1'b1;
          dbg_disp1 <= nib;
        end
      end
    end
  end
endmodule

// File: tb/tb_io_2to1.sv
// tb_io_2to1: the bench plays the merge node, forwarding source messages to the sink
// and scoring source fields and sink LED/display state against a reference model.
module tb_io_2to1;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [3:0] o0_src, o0_dst, o0_red, o1_src, o1_dst, o1_red;
  logic [3:0] i0_src = '0, i0_dst = '0, i0_red = '0;
  logic [7:0] o0_dat, o1_dat, i0_dat = '0;
  logic o0_req, o1_req, i0_ack;
  logic o0_ack = 1'b0, o1_ack = 1'b0, i0_req = 1'b0;
  logic [3:0] dbg_leds, dbg_disp0, dbg_disp1;

  typedef struct packed {logic rst; logic [3:0] leds; logic [3:0] d0; logic [3:0] d1;} exp_t;
  exp_t sbq[$], snapq[$], me;
  int vectors = 0, miscompares = 0;
  logic [3:0] ecnt[2];
  logic pr0 = 1'b0, pr1 = 1'b0, pack = 1'b0;
  logic [3:0] mleds, mlast[2], md[2];
  logic mval[2];

  always #5 clk = ~clk;

  io_2to1 #(.DST_ADDR(1), .SRC0_ADDR(9), .SRC1_ADDR(10), .GAP0(0), .GAP1(7),
            .ASZ(4), .DSZ(8), .RSZ(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .o0_src(o0_src), .o0_dst(o0_dst), .o0_dat(o0_dat), .o0_red(o0_red), .o0_req(o0_req), .o0_ack(o0_ack),
    .o1_src(o1_src), .o1_dst(o1_dst), .o1_dat(o1_dat), .o1_red(o1_red), .o1_req(o1_req), .o1_ack(o1_ack),
    .i0_src(i0_src), .i0_dst(i0_dst), .i0_dat(i0_dat), .i0_red(i0_red), .i0_req(i0_req), .i0_ack(i0_ack),
    .dbg_leds(dbg_leds), .dbg_disp0(dbg_disp0), .dbg_disp1(dbg_disp1));

  function automatic logic [3:0] fold(input logic [3:0] s, input logic [3:0] d, input logic [7:0] x);
    return s ^ d ^ x[7:4] ^ x[3:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: the only process that compares
  always @(negedge clk) begin
    if (!reset_n) begin
      ecnt[0] = 4'd0;
      ecnt[1] = 4'd0;
    end else begin
      if (o0_req && !pr0) begin
        chk("src0 msg", 64'({o0_src, o0_dst, o0_dat, o0_red}),
            64'({4'd9, 4'd1, 4'd0, ecnt[0], fold(4'd9, 4'd1, {4'd0, ecnt[0]})}));
        ecnt[0] = ecnt[0] + 4'd1;
      end
      if (o1_req && !pr1) begin
        chk("src1 msg", 64'({o1_src, o1_dst, o1_dat, o1_red}),
            64'({4'd10, 4'd1, 4'd0, ecnt[1], fold(4'd10, 4'd1, {4'd0, ecnt[1]})}));
        ecnt[1] = ecnt[1] + 4'd1;
      end
      if (i0_ack && !pack) begin
        chk("sink ack expected", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          me = sbq.pop_front();
          chk("sink leds/disp", 64'({dbg_leds, dbg_disp0, dbg_disp1}), 64'({me.leds, me.d0, me.d1}));
        end
      end
    end
    if (snapq.size() != 0) begin
      me = snapq.pop_front();
      chk("snapshot leds/disp", 64'({dbg_leds, dbg_disp0, dbg_disp1}), 64'({me.leds, me.d0, me.d1}));
      if (me.rst)
        chk("reset outputs",
            64'({o0_src, o0_dst, o0_dat, o0_red, o0_req, o1_src, o1_dst, o1_dat, o1_red, o1_req, i0_ack}),
            64'({4'd9, 4'd1, 8'd0, 4'd0, 1'b0, 4'd10, 4'd1, 8'd0, 4'd0, 1'b0, 1'b0}));
    end
    pr0  = o0_req;
    pr1  = o1_req;
    pack = i0_ack;
  end

  function automatic logic sig(input int w);
    return w == 0 ? o0_req : w == 1 ? o1_req : i0_ack;
  endfunction

  task automatic wait_sig(input int w, input logic val, input string nm);
    int n = 0;
    while (sig(w) !== val) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        $display("FAIL timeout %s", nm);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic model_reset();
    mleds = '0;
    for (int k = 0; k < 2; k++) begin
      mval[k]  = 1'b0;
      mlast[k] = '0;
      md[k]    = '0;
    end
  endtask

  task automatic model_acc(input logic [3:0] fs, input logic [3:0] fd, input logic [3:0] fr, input logic [7:0] fx);
    int k;
    if (fd != 4'd1 || (fs != 4'd9 && fs != 4'd10) || fr != fold(fs, fd, fx) || fx[7:4] != 4'd0) mleds[0] = 1'b1;
    if (fs == 4'd9 || fs == 4'd10) begin
      k = fs == 4'd10 ? 1 : 0;
      if (mval[k] && fx[3:0] != 4'(mlast[k] + 4'd1)) mleds[1+k] = 1'b1;
      mlast[k] = fx[3:0];
      mval[k]  = 1'b1;
      md[k]    = fx[3:0];
    end
  endtask

  // reset asserted mid-cycle so only an asynchronous reset clears outputs by the next check
  task automatic do_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    o0_ack = 1'b0;
    o1_ack = 1'b0;
    i0_req = 1'b0;
    model_reset();
    snapq.push_back(exp_t'({1'b1, 12'd0}));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // mode: 0 clean, 1 corrupt red bit 0, 2 drop, 3 abort then retry, 4 hold sink handshake open
  task automatic xfer(input int s, input int mode, input int dly);
    logic [3:0] fs, fd, fr;
    logic [7:0] fx;
    wait_sig(s, 1'b1, "src req");
    fs = s != 0 ? o1_src : o0_src;
    fd = s != 0 ? o1_dst : o0_dst;
    fx = s != 0 ? o1_dat : o0_dat;
    fr = s != 0 ? o1_red : o0_red;
    if (mode == 1) fr[0] = ~fr[0];
    if (mode != 2) begin
      i0_src = fs;
      i0_dst = fd;
      i0_dat = fx;
      i0_red = fr;
      if (mode == 3) begin
        i0_req = 1'b1;
        @(negedge clk);
        i0_req = 1'b0;
        repeat (2) @(negedge clk);
        mleds[3] = 1'b1;
        snapq.push_back(exp_t'({1'b0, mleds, md[0], md[1]}));
        repeat (2) @(negedge clk);
      end
      model_acc(fs, fd, fr, fx);
      sbq.push_back(exp_t'({1'b0, mleds, md[0], md[1]}));
      i0_req = 1'b1;
      wait_sig(2, 1'b1, "sink ack");
      if (mode == 4) return;
      repeat (dly) @(negedge clk);
      i0_req = 1'b0;
      wait_sig(2, 1'b0, "sink release");
    end
    repeat (dly) @(negedge clk);
    if (s != 0) o1_ack = 1'b1;
    else o0_ack = 1'b1;
    wait_sig(s, 1'b0, "src release");
    o0_ack = 1'b0;
    o1_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    snapq.push_back(exp_t'({1'b1, 12'd0}));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) xfer(i % 2, 0, 0);
    do_reset();
    for (int i = 0; i < 21; i++) xfer(i % 2, i == 5 ? 1 : 0, 0);
    do_reset();
    for (int i = 0; i < 8; i++) xfer(i % 2, i == 5 ? 2 : 0, 0);
    do_reset();
    for (int i = 0; i < 6; i++) xfer(i % 2, i == 2 ? 3 : 0, 0);
    do_reset();
    xfer(0, 0, 0);
    xfer(1, 0, 0);
    xfer(0, 4, 0);
    do_reset();
    xfer(0, 0, 0);
    xfer(1, 0, 0);
    for (int i = 0; i < 100; i++) xfer(int'($urandom_range(0, 1)), 0, int'($urandom_range(0, 4)));
    snapq.push_back(exp_t'({1'b0, mleds, md[0], md[1]}));
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
